// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state encodings and defaults for the nibble-serial ALU
package alu_pkg;

   localparam int NIBBLES_DEF = 8;

   typedef enum logic [2:0] {
      OP_CLR = 3'b000,
      OP_BMA = 3'b001,
      OP_AMB = 3'b010,
      OP_ADD = 3'b011,
      OP_XOR = 3'b100,
      OP_OR  = 3'b101,
      OP_AND = 3'b110,
      OP_SET = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_nibble.sv
// rtl/alu_nibble.sv - combinational 4-bit ALU slice; exposes carry into bit 3 for overflow
module alu_nibble
   import alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] s,
   input  logic       ci,
   output logic [3:0] f,
   output logic       co,
   output logic       c3
);

   logic [3:0] w_x;
   logic [3:0] w_y;
   logic [3:0] w_lo;
   logic       w_arith;

   always_comb begin
      w_x     = a;
      w_y     = b;
      w_lo    = 4'h0;
      w_arith = 1'b0;
      f       = 4'h0;
      co      = 1'b0;
      c3      = 1'b0;
      case (op_e'(s))
         OP_CLR: f = 4'h0;
         OP_BMA: begin w_x = b; w_y = ~a; w_arith = 1'b1; end
         OP_AMB: begin w_x = a; w_y = ~b; w_arith = 1'b1; end
         OP_ADD: w_arith = 1'b1;
         OP_XOR: f = a ^ b;
         OP_OR:  f = a | b;
         OP_AND: f = a & b;
         OP_SET: f = 4'hF;
         default: f = 4'h0;
      endcase
      // Split the add at bit 3 so the carry into the top bit is visible.
      if (w_arith) begin
         w_lo = {1'b0, w_x[2:0]} + {1'b0, w_y[2:0]} + {3'b000, ci};
         c3   = w_lo[3];
         f    = {w_x[3] ^ w_y[3] ^ c3, w_lo[2:0]};
         co   = (w_x[3] & w_y[3]) | (c3 & (w_x[3] ^ w_y[3]));
      end
   end

endmodule

// File: rtl/nibble_alu_seq.sv
// rtl/nibble_alu_seq.sv - word ALU computed one nibble per clock through a single shared slice
module nibble_alu_seq
   import alu_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic [2:0]             s,
   input  logic                   cin,
   input  logic                   abort,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   f,
   output logic                   cout,
   output logic                   overflow,
   output logic                   zero
);

   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   state_e        r_state;
   state_e        w_next;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [2:0]    r_s;
   logic [KW-1:0] r_k;
   logic          r_carry;
   logic [W-1:0]  r_f;
   logic          r_cout;
   logic          r_ovf;

   logic [3:0]    w_a_nib;
   logic [3:0]    w_b_nib;
   logic [3:0]    w_f_nib;
   logic          w_co;
   logic          w_c3;

   always_comb begin
      w_a_nib = 4'h0;
      w_b_nib = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (r_k == KW'(i)) begin
            w_a_nib = r_a[i*4 +: 4];
            w_b_nib = r_b[i*4 +: 4];
         end
      end
   end

   alu_nibble u_slice (
      .a  (w_a_nib),
      .b  (w_b_nib),
      .s  (r_s),
      .ci (r_carry),
      .f  (w_f_nib),
      .co (w_co),
      .c3 (w_c3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)        w_next = ST_RUN;
         ST_RUN: begin
            if (abort)                 w_next = ST_IDLE;
            else if (r_k == K_LAST)    w_next = ST_DONE;
         end
         ST_DONE: if (out_ready)       w_next = ST_IDLE;
         default:                      w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= 3'b000;
         r_k     <= '0;
         r_carry <= 1'b0;
         r_f     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_s     <= s;
                  r_k     <= '0;
                  r_carry <= cin;
               end
            end
            ST_RUN: begin
               // Abort freezes everything, so f keeps its partially written value.
               if (!abort) begin
                  for (int i = 0; i < NIBBLES; i++) begin
                     if (r_k == KW'(i)) r_f[i*4 +: 4] <= w_f_nib;
                  end
                  r_carry <= w_co;
                  r_k     <= r_k + 1'b1;
                  if (r_k == K_LAST) begin
                     r_cout <= w_co;
                     r_ovf  <= w_co ^ w_c3;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign f         = r_f;
   assign cout      = r_cout;
   assign overflow  = r_ovf;
   assign zero      = (r_f == '0);

endmodule

// File: doc/nibble_alu_seq.md
NIBBLE_ALU_SEQ -- requirements
Module: nibble_alu_seq

Interface
REQ-001 SHALL provide the following ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode offer.
- in_ready  out  1  block can accept.
- a  in  32  operand A.
- b  in  32  operand B.
- s  in  3  opcode.
- cin  in  1  carry into bit 0.
- abort  in  1  sync cancel of an in-flight op.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- f  out  32  result.
- cout  out  1  carry out of bit 31.
- overflow  out  1  signed overflow at bit 31.
- zero  out  1  f == 0.

REQ-002 SHALL use the parameter NIBBLES, default 8, meaning the number of 4-bit passes per word; datapath width is 4*NIBBLES.

Function
REQ-003 SHALL implement states IDLE, RUN and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE.
REQ-005 out_valid SHALL be 1 only in DONE.
REQ-006 On a clk edge with in_valid&in_ready, SHALL latch a, b, s and cin, clear nibble index k to 0, set carry register to cin, and go to RUN.
REQ-007 In RUN, each edge SHALL compute nibble k with the slice and write f[4k+3:4k], then update the carry register and increment k.
REQ-008 After the edge that processes k = NIBBLES-1, SHALL go to DONE.
- Acceptance at edge T0 gives out_valid high from edge T8.
- Latency is 8 edges for NIBBLES=8.
REQ-009 Opcode semantics per word:
- 000: f=0.
- 001: f=B+~A+cin.
- 010: f=A+~B+cin.
- 011: f=A+B+cin.
- 100: A^B.
- 101: A|B.
- 110: A&B.
- 111: f=all ones.
REQ-010 For arithmetic ops 001..011, cout SHALL be the carry out of bit 31, and overflow SHALL be carry-into-bit-31 XOR carry-out-of-bit-31.
REQ-011 For ops 000 and 100..111, cout and overflow SHALL be 0.
REQ-012 zero SHALL equal (f==0) and be valid whenever out_valid is 1.
REQ-013 f, cout, overflow and zero SHALL remain stable while in DONE.
REQ-014 In DONE, an edge with out_ready=1 SHALL return to IDLE; with out_ready=0, the block SHALL hold DONE indefinitely.
REQ-015 abort=1 in RUN SHALL return to IDLE on that edge, leaving f unchanged from its partial value and out_valid never asserted for that op.
REQ-016 abort SHALL be ignored in IDLE and DONE.
REQ-017 in_valid while not in IDLE SHALL be ignored, with no latch and no state change.
REQ-018 Changes to a/b/s/cin after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-019 rst=1 SHALL asynchronously force state IDLE, k=0, carry=0, f=0, cout=0, overflow=0, zero=1, out_valid=0 and in_ready=1.
REQ-020 Reset asserted mid-RUN or in DONE SHALL discard the operation; the first acceptance SHALL be possible on the first edge after rst deasserts.

Structure
REQ-021 Opcode encodings (OP_CLR..OP_SET), state encodings and NIBBLES default SHALL live in a shared package alu_pkg.
REQ-022 The combinational 4-bit slice SHALL be a separate sub-module alu_nibble with ports a[3:0], b[3:0], s, ci, f[3:0], co and c3 (carry into bit 3); nibble_alu_seq SHALL instantiate exactly one.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- s=011, a=0x7FFFFFFF, b=1, cin=0 -> f=0x80000000, cout=0, overflow=1, zero=0, out_valid 8 edges after accept.
- s=001, a=5, b=3, cin=1 -> f=0xFFFFFFFE, cout=0, overflow=0.
- s=010, a=0x12345678, b=0x12345678, cin=1 -> f=0, zero=1, cout=1, overflow=0.
- s=110, a=0xF0F0F0F0, b=0xFF00FF00 with out_ready held 0 for 5 cycles -> f=0xF000F000, cout=0, outputs stable, in_ready=0 until the out_ready edge.
- abort asserted at RUN k=3 -> returns to IDLE, out_valid never 1; the next op s=111 -> f=0xFFFFFFFF.
- rst pulsed asynchronously mid-RUN (between edges) -> outputs immediately reach reset values; a subsequent s=000 -> f=0, zero=1.
